// File: rtl/pic_inta_sequencer_if.sv
// Bus bundle between the 8259 IRQ/priority stage, the OCW decode, the CPU
// acknowledge input and the data-bus driver on one side, and the INTA
// sequencer on the other.
//   master : the surrounding PIC logic / CPU side (drives requests, mask,
//            ICW fields, INTA and EOI strobes; receives INT, ISR, vector)
//   slave  : pic_inta_sequencer
// Signals:
//   irr[7:0]         pending requests             (master -> slave)
//   imr[7:0]         mask, 1 = masked             (master -> slave)
//   vector_base[4:0] ICW2 T7..T3                  (master -> slave)
//   auto_eoi         ICW4 AEOI                    (master -> slave)
//   INTA             acknowledge, active low      (master -> slave)
//   eoi_nonspecific  one-cycle strobe             (master -> slave)
//   eoi_specific     one-cycle strobe             (master -> slave)
//   eoi_level[2:0]   level for specific EOI       (master -> slave)
//   INT              interrupt request to CPU     (slave -> master)
//   isr[7:0]         in-service register          (slave -> master)
//   irr_clear[7:0]   one-hot IRR clear pulse      (slave -> master)
//   vector_data[7:0] vector byte                  (slave -> master)
//   vector_drive     data-bus drive enable        (slave -> master)
interface pic_inta_sequencer_if;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       INTA;
  logic       eoi_nonspecific;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       INT;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic [7:0] vector_data;
  logic       vector_drive;

  modport master (
    output irr, imr, vector_base, auto_eoi, INTA,
           eoi_nonspecific, eoi_specific, eoi_level,
    input  INT, isr, irr_clear, vector_data, vector_drive
  );

  modport slave (
    input  irr, imr, vector_base, auto_eoi, INTA,
           eoi_nonspecific, eoi_specific, eoi_level,
    output INT, isr, irr_clear, vector_data, vector_drive
  );
endinterface

// File: rtl/pic_inta_sequencer.sv
// 8259 interrupt-acknowledge sequencer (8086 mode, two INTA pulses).
// Fully-nested fixed priority (IR0 highest), drives INT, maintains the
// in-service register (set on first INTA, cleared by EOI or auto-EOI) and
// presents the vector byte {vector_base, level} during the second INTA pulse.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : pic_inta_sequencer_if.slave (see interface file for signals)
module pic_inta_sequencer (
  input  logic                       clk,
  input  logic                       reset,
  pic_inta_sequencer_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } state_t;

  state_t     state_reg;
  logic       inta_q_reg;
  logic       int_reg;
  logic [7:0] isr_reg;
  logic [7:0] isr_next;
  logic [7:0] irr_clear_reg;
  logic [7:0] vector_data_reg;
  logic       vector_drive_reg;
  logic [2:0] level_reg;
  logic       spurious_reg;

  logic [7:0] cand;
  logic [2:0] win_lvl;
  logic       win_any;
  logic [2:0] isr_lvl;
  logic       isr_any;
  logic       winner_valid;
  logic       fall;
  logic       rise;
  logic [7:0] clr_mask;
  logic [7:0] set_mask;

  assign fall = inta_q_reg & ~bus.INTA;
  assign rise = ~inta_q_reg & bus.INTA;
  assign cand = bus.irr & ~bus.imr;

  // Lowest set index of the candidates and of the ISR. Scanning downward
  // leaves the lowest index as the last assignment.
  always_comb begin
    win_lvl = 3'd0;
    win_any = 1'b0;
    isr_lvl = 3'd0;
    isr_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) begin
        win_lvl = 3'(i);
        win_any = 1'b1;
      end
      if (isr_reg[i]) begin
        isr_lvl = 3'(i);
        isr_any = 1'b1;
      end
    end
    // Fully nested: a request is only granted if strictly higher priority
    // than everything already in service.
    winner_valid = win_any && (!isr_any || (win_lvl < isr_lvl));
  end

  // ISR clear sources (EOI, auto-EOI) and the set from the first INTA.
  always_comb begin
    clr_mask = 8'h00;
    set_mask = 8'h00;
    if (bus.eoi_specific)
      clr_mask[bus.eoi_level] = 1'b1;
    else if (bus.eoi_nonspecific && isr_any)
      clr_mask[isr_lvl] = 1'b1;
    if ((state_reg == ACK2) && rise && bus.auto_eoi && !spurious_reg)
      clr_mask[level_reg] = 1'b1;
    if ((state_reg == IDLE) && fall && winner_valid)
      set_mask[win_lvl] = 1'b1;
  end

  // Clears apply first, then the set, so a set on the same bit wins.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_isr_bit
      assign isr_next[gi] = set_mask[gi] | (isr_reg[gi] & ~clr_mask[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      inta_q_reg       <= 1'b0;
      int_reg          <= 1'b0;
      isr_reg          <= 8'h00;
      irr_clear_reg    <= 8'h00;
      vector_data_reg  <= 8'h00;
      vector_drive_reg <= 1'b0;
      level_reg        <= 3'd0;
      spurious_reg     <= 1'b0;
    end else begin
      inta_q_reg    <= bus.INTA;
      isr_reg       <= isr_next;
      irr_clear_reg <= set_mask;
      int_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          int_reg <= winner_valid;
          if (fall) begin
            // No valid winner: acknowledge as spurious IR7, ISR untouched.
            level_reg    <= winner_valid ? win_lvl : 3'd7;
            spurious_reg <= ~winner_valid;
            int_reg      <= 1'b0;
            state_reg    <= ACK1;
          end
        end
        ACK1: begin
          if (rise)
            state_reg <= WAIT2;
        end
        WAIT2: begin
          if (fall) begin
            vector_drive_reg <= 1'b1;
            vector_data_reg  <= {bus.vector_base, level_reg};
            state_reg        <= ACK2;
          end
        end
        ACK2: begin
          if (rise) begin
            vector_drive_reg <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.INT          = int_reg;
  assign bus.isr          = isr_reg;
  assign bus.irr_clear    = irr_clear_reg;
  assign bus.vector_data  = vector_data_reg;
  assign bus.vector_drive = vector_drive_reg;

endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

Synchronous interrupt-acknowledge sequencer for the 8259 PIC: takes latched requests from the IRQ register stage and the mask, performs fully-nested fixed-priority arbitration against the in-service register, and drives INT. It runs the two-pulse 8086-mode INTA handshake, sets and clears the in-service register (including EOI and auto-EOI), and supplies the interrupt vector byte to the data-bus driver. It sits between the IRQ/priority stage and the read/write data-bus logic.

## Interface
- No parameters. Fixed 8 levels; IR0 highest, IR7 lowest; no rotation.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- irr  input  8  pending requests from the IRQ register stage
- imr  input  8  mask; 1 = level masked
- vector_base  input  5  ICW2 bits T7..T3
- auto_eoi  input  1  ICW4 AEOI bit
- INTA  input  1  CPU acknowledge, active low, already synchronous to clk
- eoi_nonspecific  input  1  one-cycle strobe from OCW2 decode
- eoi_specific  input  1  one-cycle strobe from OCW2 decode
- eoi_level  input  3  level for specific EOI
- INT  output  1  interrupt request to CPU, registered
- isr  output  8  in-service register
- irr_clear  output  8  one-hot one-cycle pulse clearing the acknowledged IRR bit
- vector_data  output  8  vector byte {vector_base, level}
- vector_drive  output  1  data-bus drive enable for vector_data

## Operation
- Candidates: c = irr & ~imr. Winner w = lowest index set in c. Valid only if w < lowest index set in isr (or isr == 0). Fully nested: equal or lower priority than any in-service level is blocked.
- INTA edges: inta_q registers INTA each cycle. fall = inta_q & ~INTA; rise = ~inta_q & INTA. inta_q resets to 0, so INTA held low through reset release produces no fall.
- States: IDLE, ACK1, WAIT2, ACK2.
- IDLE: INT <= winner_valid. On fall: latch level = w if winner_valid, otherwise level = 7 (spurious, ISR not set). If valid: set isr[w], irr_clear[w] = 1 for that cycle. INT <= 0. Go to ACK1.
- ACK1: on rise, go to WAIT2. A fall cannot occur.
- WAIT2: on fall, go to ACK2; vector_drive <= 1; vector_data <= {vector_base, level}.
- ACK2: on rise, vector_drive <= 0 and go to IDLE. If auto_eoi = 1 and the acknowledge was not spurious, clear isr[level] in the same cycle.
- INT is held 0 throughout ACK1, WAIT2 and ACK2. It is re-evaluated in IDLE from the cycle after entry.
- EOI is accepted in any state.
  - Non-specific: clear the lowest-index set bit of isr. No effect if isr == 0.
  - Specific: clear isr[eoi_level].
  - If both strobes are high, specific wins.
- Same cycle as an ISR set: clears are applied first, then the set. If both target the same bit, the set wins.
- irr and imr changes during ACK1/WAIT2/ACK2 do not alter the latched level.
- Reset values: state IDLE, INT 0, isr 0x00, irr_clear 0x00, vector_data 0x00, vector_drive 0, level 0, inta_q 0.
- Reset in any state returns to IDLE the next edge, drops vector_drive and clears isr.

## Timing
- Request to INT: irr/imr change at edge N gives INT = 1 after edge N+1 (one register).
- fall is detected in the cycle INTA is first sampled low. isr set and irr_clear pulse are visible after the next edge. INT is 0 after that same edge.
- vector_drive and vector_data become valid one edge after the second fall is detected. vector_drive drops one edge after the second rise is detected. Each INTA low phase must be at least 2 clk cycles.
- Auto-EOI clear is visible after the same edge that drops vector_drive.
- EOI strobe at edge N: isr updated after edge N. INT can re-assert after edge N+1.

## Test plan
- Basic ack, no mask: vector_base = 5'b01000, irr = 0x04. Expect INT = 1. Two INTA pulses → isr = 0x04, irr_clear = 0x04 for one cycle, vector_data = 0x42 with vector_drive high during the second pulse only.
- Priority and nesting: irr = 0x0A. First ack → level 1, isr = 0x02. IR3 stays blocked with INT = 0 until a non-specific EOI clears isr, then INT = 1 and the next ack returns level 3.
- Masking and spurious: irr = 0x10, imr = 0x10 → INT stays 0. Force an INTA pair anyway → vector_data = {vector_base, 3'd7}, isr remains 0x00, irr_clear stays 0x00.
- Auto-EOI: auto_eoi = 1, irr = 0x01. After second INTA rise, isr returns to 0x00 on the same edge vector_drive falls.
- Specific EOI collision: isr = 0x06. eoi_specific with eoi_level = 2 → isr = 0x02. Then assert both strobes with eoi_level = 1 → isr = 0x00.
- Reset mid-handshake: assert reset in WAIT2 with isr = 0x08 → next cycle isr = 0x00, INT = 0, vector_drive = 0, state IDLE. INTA held low across reset release → no acknowledge starts.
